ldpc_frame_loader: RTL and testbench

Input staging stage directly upstream of the LDPC decoder top. It collects a serial stream of hard-decision channel words into a full R*D-bit codeword frame, holds the frame stable on the decoder's `sig` input and issues a one-cycle start pulse to launch each decode. A second, internal frame buffer lets the next codeword fill while the decoder works on the current one. Decoder completion is signalled back to this block on `dec_done`.

---
 rtl/ldpc_frame_loader.sv | 129 ++++++++++++
 tb/tb_ldpc_frame_loader.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ldpc_frame_loader.sv
// ldpc_frame_loader
// Sits in front of the LDPC decoder. It collects IN_W-bit hard-decision words
// into an N = R*D bit frame, hands each finished frame to the decoder on `sig`
// with a one-cycle `dec_start` pulse, and fills the next frame while the
// decoder is working on the current one.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous reset, active-low
//   in_data    in   IN_W   input word; word k of a frame lands in sig[k*IN_W +: IN_W]
//   in_valid   in   1      in_data is valid this cycle
//   in_ready   out  1      a word is accepted this cycle (high while filling)
//   dec_done   in   1      one-cycle pulse, the decoder finished its frame
//   sig        out  N      frame presented to the decoder (registered)
//   dec_start  out  1      one-cycle launch pulse (registered)
//   busy       out  1      the decoder holds an unfinished frame
//   frame_cnt  out  CNT_W  frames launched since reset, wraps
module ldpc_frame_loader #(
  parameter int R     = 32,
  parameter int D     = 64,
  parameter int IN_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             dec_done,
  output logic [R*D-1:0]   sig,
  output logic             dec_start,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int N    = R * D;
  localparam int W    = N / IN_W;
  localparam int WC_W = (W > 1) ? $clog2(W) : 1;

  if (N % IN_W != 0) begin : g_bad_width
    $error("ldpc_frame_loader: R*D must be a multiple of IN_W");
  end

  typedef enum logic {FILL, FULL} state_t;

  state_t            state_q, state_d;
  logic [WC_W-1:0]   wcnt_q, wcnt_d;
  logic [N-1:0]      fbuf_q, fbuf_d;
  logic [N-1:0]      sig_q, sig_d;
  logic              dec_start_q, dec_start_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic              launch;

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    fbuf_d      = fbuf_q;
    sig_d       = sig_q;
    dec_start_d = 1'b0;
    busy_d      = busy_q;
    frame_cnt_d = frame_cnt_q;
    launch      = 1'b0;

    case (state_q)
      FILL: begin
        if (in_valid) begin
          fbuf_d[int'(wcnt_q) * IN_W +: IN_W] = in_data;
          if (wcnt_q == WC_W'(W - 1)) begin
            wcnt_d  = '0;
            state_d = FULL;
          end else begin
            wcnt_d = wcnt_q + WC_W'(1);
          end
        end
      end
      FULL: begin
        // A completing decoder frees the slot in the same cycle, so a frame
        // waiting here goes out back-to-back with no idle cycle.
        if (!busy_q || dec_done) begin
          launch      = 1'b1;
          sig_d       = fbuf_q;
          dec_start_d = 1'b1;
          frame_cnt_d = frame_cnt_q + CNT_W'(1);
          state_d     = FILL;
        end
      end
      default: state_d = FILL;
    endcase

    // Launch has priority over a coincident dec_done.
    if (launch) begin
      busy_d = 1'b1;
    end else if (dec_done) begin
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FILL;
      wcnt_q      <= '0;
      sig_q       <= '0;
      dec_start_q <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      sig_q       <= sig_d;
      dec_start_q <= dec_start_d;
      busy_q      <= busy_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Fill buffer holds data only; stale bits are always overwritten before
  // the next launch, so it needs no reset.
  always_ff @(posedge clk) begin
    fbuf_q <= fbuf_d;
  end

  assign in_ready  = (state_q == FILL);
  assign sig       = sig_q;
  assign dec_start = dec_start_q;
  assign busy      = busy_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_ldpc_frame_loader.sv
module tb_ldpc_frame_loader;

  localparam int N = 2048;
  localparam int W = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   in_data;
  logic          in_valid;
  logic          in_ready;
  logic          dec_done;
  logic [N-1:0]  sig;
  logic          dec_start;
  logic          busy;
  logic [15:0]   frame_cnt;

  // Small instance for the counter wrap: N = 8, W = 2, CNT_W = 2
  logic          w_rst;
  logic [3:0]    w_in_data;
  logic          w_in_valid;
  logic          w_in_ready;
  logic          w_dec_done;
  logic [7:0]    w_sig;
  logic          w_dec_start;
  logic          w_busy;
  logic [1:0]    w_frame_cnt;

  int vecs = 0;
  int errs = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  ldpc_frame_loader dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .dec_done(dec_done), .sig(sig),
    .dec_start(dec_start), .busy(busy), .frame_cnt(frame_cnt)
  );

  ldpc_frame_loader #(.R(2), .D(4), .IN_W(4), .CNT_W(2)) dut_w (
    .clk(clk), .rst(w_rst), .in_data(w_in_data), .in_valid(w_in_valid),
    .in_ready(w_in_ready), .dec_done(w_dec_done), .sig(w_sig),
    .dec_start(w_dec_start), .busy(w_busy), .frame_cnt(w_frame_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] mk_frame(input int base);
    logic [N-1:0] r;
    for (int k = 0; k < W; k++) r[k*32 +: 32] = 32'(base + k);
    return r;
  endfunction

  function automatic int first_diff(input logic [N-1:0] a, input logic [N-1:0] b);
    for (int k = 0; k < W; k++) if (a[k*32 +: 32] !== b[k*32 +: 32]) return k;
    return -1;
  endfunction

  // Feeds one frame of words base..base+W-1; returns in the first FULL cycle.
  task automatic send_frame(input int base, input bit gapped);
    int acc = 0;
    int cyc = 0;
    while (acc < W) begin
      in_valid = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = 32'(base + acc);
      if (in_valid && in_ready) acc++;
      tick();
      cyc++;
      if (cyc > 1000) begin
        vecs++; errs++;
        $display("FAIL send_frame_timeout: accepted %0d words, required %0d", acc, W);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; w_rst = 1'b0;
    in_valid = 0; in_data = 0; dec_done = 0;
    w_in_valid = 0; w_in_data = 0; w_dec_done = 0;
    #23;
    vecs++; if (sig !== '0) begin errs++; $display("FAIL reset_sig: got nonzero, required 0"); end
    vecs++; if (dec_start !== 1'b0) begin errs++; $display("FAIL reset_dec_start: got %b required 0", dec_start); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b required 0", busy); end
    vecs++; if (frame_cnt !== 16'd0) begin errs++; $display("FAIL reset_frame_cnt: got %0d required 0", frame_cnt); end
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    tick();
    rst = 1'b1; w_rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [N-1:0] e = mk_frame(0);
    int rdy_low = 0;
    send_frame(0, 1'b0);
    // first FULL cycle: no room, no launch yet
    vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL single_full_ready: got %b required 0", in_ready); end
    vecs++; if (dec_start !== 1'b0) begin errs++; $display("FAIL single_early_start: got %b required 0", dec_start); end
    tick();
    exp_cnt++;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL single_ready_back: got %b required 1", in_ready); end
    vecs++; if (dec_start !== 1'b1) begin errs++; $display("FAIL single_start: got %b required 1", dec_start); end
    vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL single_busy: got %b required 1", busy); end
    vecs++; if (frame_cnt !== 16'(exp_cnt)) begin errs++; $display("FAIL single_cnt: got %0d required %0d", frame_cnt, exp_cnt); end
    vecs++; if (sig !== e) begin errs++; $display("FAIL single_sig: word %0d got %h required %h", first_diff(sig, e), sig[first_diff(sig, e)*32 +: 32], e[first_diff(sig, e)*32 +: 32]); end
    tick();
    vecs++; if (dec_start !== 1'b0) begin errs++; $display("FAIL single_start_len: got %b required 0", dec_start); end
    if (in_ready !== 1'b1) rdy_low++;
    vecs++; if (rdy_low != 0) begin errs++; $display("FAIL single_ready_after: got in_ready %b required 1", in_ready); end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] e1 = mk_frame(0);
    logic [N-1:0] e2 = mk_frame(1000);
    int bad = 0;
    send_frame(1000, 1'b0);
    // decoder still busy on frame 1: hold until dec_done
    for (int c = 0; c < 30; c++) begin
      if (in_ready !== 1'b0 || dec_start !== 1'b0 || sig !== e1 || busy !== 1'b1) bad++;
      tick();
    end
    vecs++; if (bad != 0) begin errs++; $display("FAIL bp_hold: %0d cycles not held, required 0", bad); end
    dec_done = 1'b1;
    tick();
    dec_done = 1'b0;
    exp_cnt++;
    vecs++; if (dec_start !== 1'b1) begin errs++; $display("FAIL bp_start: got %b required 1", dec_start); end
    vecs++; if (sig !== e2) begin errs++; $display("FAIL bp_sig: first bad word %0d", first_diff(sig, e2)); end
    vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL bp_busy: got %b required 1", busy); end
    vecs++; if (frame_cnt !== 16'(exp_cnt)) begin errs++; $display("FAIL bp_cnt: got %0d required %0d", frame_cnt, exp_cnt); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] e3 = mk_frame(2000);
    send_frame(2000, 1'b0);
    vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL b2b_busy_pre: got %b required 1", busy); end
    dec_done = 1'b1;
    tick();
    dec_done = 1'b0;
    exp_cnt++;
    vecs++; if (dec_start !== 1'b1) begin errs++; $display("FAIL b2b_start: got %b required 1", dec_start); end
    vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL b2b_busy: got %b required 1", busy); end
    vecs++; if (frame_cnt !== 16'(exp_cnt)) begin errs++; $display("FAIL b2b_cnt: got %0d required %0d", frame_cnt, exp_cnt); end
    vecs++; if (sig !== e3) begin errs++; $display("FAIL b2b_sig: first bad word %0d", first_diff(sig, e3)); end
    tick();
  endtask

  task automatic test_gapped();
    int base_cnt;
    // dec_done while filling just frees the decoder
    dec_done = 1'b1;
    tick();
    dec_done = 1'b0;
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL fill_done_busy: got %b required 0", busy); end
    vecs++; if (dec_start !== 1'b0) begin errs++; $display("FAIL fill_done_start: got %b required 0", dec_start); end
    base_cnt = exp_cnt;
    for (int f = 0; f < 3; f++) begin
      logic [N-1:0] e = mk_frame(3000 + 100 * f);
      send_frame(3000 + 100 * f, 1'b1);
      tick();
      exp_cnt++;
      vecs++; if (dec_start !== 1'b1) begin errs++; $display("FAIL gap_start%0d: got %b required 1", f, dec_start); end
      vecs++; if (sig !== e) begin errs++; $display("FAIL gap_sig%0d: first bad word %0d", f, first_diff(sig, e)); end
      for (int c = 0; c < 49; c++) tick();
      dec_done = 1'b1;
      tick();
      dec_done = 1'b0;
    end
    vecs++; if (frame_cnt - 16'(base_cnt) !== 16'd3) begin errs++; $display("FAIL gap_cnt: got %0d launches required 3", frame_cnt - 16'(base_cnt)); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL gap_busy_end: got %b required 0", busy); end
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] e = mk_frame(5000);
    send_frame(4000, 1'b0);
    tick();
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'b1; in_data = 32'(7000 + k);
      tick();
    end
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    vecs++; if (sig !== '0) begin errs++; $display("FAIL rstmid_sig: got nonzero required 0"); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rstmid_busy: got %b required 0", busy); end
    vecs++; if (frame_cnt !== 16'd0) begin errs++; $display("FAIL rstmid_cnt: got %0d required 0", frame_cnt); end
    vecs++; if (dec_start !== 1'b0 || in_ready !== 1'b1) begin errs++; $display("FAIL rstmid_ctl: got start %b ready %b required 0 1", dec_start, in_ready); end
    tick();
    rst = 1'b1;
    tick(); tick();
    vecs++; if (dec_start !== 1'b0 || frame_cnt !== 16'd0) begin errs++; $display("FAIL rstmid_stale: got start %b cnt %0d required 0 0", dec_start, frame_cnt); end
    send_frame(5000, 1'b0);
    tick();
    vecs++; if (dec_start !== 1'b1) begin errs++; $display("FAIL rstmid_start: got %b required 1", dec_start); end
    vecs++; if (frame_cnt !== 16'd1) begin errs++; $display("FAIL rstmid_cnt2: got %0d required 1", frame_cnt); end
    vecs++; if (sig !== e) begin errs++; $display("FAIL rstmid_sig2: first bad word %0d", first_diff(sig, e)); end
  endtask

  task automatic test_wrap();
    logic [1:0] exp_seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [7:0] ew;
    w_dec_done = 1'b1;
    for (int f = 0; f < 5; f++) begin
      for (int k = 0; k < 2; k++) begin
        w_in_valid = 1'b1;
        w_in_data  = 4'((2 * f + k + 3) & 15);
        tick();
      end
      w_in_valid = 1'b0;
      tick();
      ew = {4'((2 * f + 4) & 15), 4'((2 * f + 3) & 15)};
      vecs++; if (w_dec_start !== 1'b1) begin errs++; $display("FAIL wrap_start%0d: got %b required 1", f, w_dec_start); end
      vecs++; if (w_frame_cnt !== exp_seq[f]) begin errs++; $display("FAIL wrap_cnt%0d: got %0d required %0d", f, w_frame_cnt, exp_seq[f]); end
      vecs++; if (w_sig !== ew) begin errs++; $display("FAIL wrap_sig%0d: got %h required %h", f, w_sig, ew); end
    end
    w_dec_done = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_gapped();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
